// File: rtl/run_ctrl_pkg.sv
// Shared types and default constants for the program-run controller.
// Latency: n/a (types only).
// Backpressure: n/a.
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RESET_CPU,
        RUN,
        DONE,
        TIMEOUT
    } run_state_t;

    localparam int          DEF_RST_CYCLES  = 2;
    localparam logic [15:0] DEF_TIMEOUT_CYC = 16'hFFF0;

endpackage

// File: rtl/run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
// Latency: count updates one clock after clear/en.
// Backpressure: none; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/run_ctrl.sv
// Sequences processor reset, run and result handshake; optional run limit under RUN_CTRL_TIMEOUT_EN.
// Latency: start->busy 1 clk, start->cpu_reset low RST_CYCLES+1 clks.
// Backpressure: result held in DONE/TIMEOUT until ack; starts outside IDLE are dropped.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int            CW          = 16,
    parameter int            RST_CYCLES  = DEF_RST_CYCLES,
    parameter logic [CW-1:0] TIMEOUT_CYC = CW'(DEF_TIMEOUT_CYC)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          ack,
    input  logic          cpu_done,
    output logic          cpu_reset,
    output logic          busy,
    output logic          finished,
    output logic          timed_out,
    output logic [CW-1:0] cycle_count
);

`ifdef RUN_CTRL_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam int TW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    run_state_t    state;
    logic [TW-1:0] timer;
    logic          timeout_hit;
    logic          cnt_clear;
    logic          cnt_en;

    // Done wins over the limit: the limit only applies when cpu_done is low.
    assign timeout_hit = TIMEOUT_EN && (cycle_count == TIMEOUT_CYC);
    assign cnt_clear   = (state == IDLE) && start;
    assign cnt_en      = (state == RUN) && !cpu_done && !timeout_hit;

    sat_counter #(
        .W (CW)
    ) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .en    (cnt_en),
        .count (cycle_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            timer     <= '0;
            cpu_reset <= 1'b1;
            busy      <= 1'b0;
            finished  <= 1'b0;
            timed_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RESET_CPU;
                        busy  <= 1'b1;
                        timer <= TW'(RST_CYCLES - 1);
                    end
                end
                RESET_CPU: begin
                    if (timer == '0) begin
                        state     <= RUN;
                        cpu_reset <= 1'b0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                RUN: begin
                    if (cpu_done) begin
                        state     <= DONE;
                        cpu_reset <= 1'b1;
                        busy      <= 1'b0;
                        finished  <= 1'b1;
                    end else if (timeout_hit) begin
                        state     <= TIMEOUT;
                        cpu_reset <= 1'b1;
                        busy      <= 1'b0;
                        timed_out <= TIMEOUT_EN;
                    end
                end
                DONE, TIMEOUT: begin
                    if (ack) begin
                        state     <= IDLE;
                        finished  <= 1'b0;
                        timed_out <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cpu_reset <= 1'b1;
                    busy      <= 1'b0;
                    finished  <= 1'b0;
                    timed_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench: vector table through a scoreboard queue, plus hand sequences
// for async reset, parameterised latency, done/limit priority and saturation/timeout.
module tb_run_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, ack, cpu_done;
    logic        cpu_reset, busy, finished, timed_out;
    logic [15:0] cycle_count;

    logic        start_s, ack_s, done_s;
    logic        cpu_reset_s, busy_s, finished_s, timed_out_s;
    logic [5:0]  count_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    run_ctrl #(
        .CW          (16),
        .RST_CYCLES  (2),
        .TIMEOUT_CYC (16'd20)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .ack         (ack),
        .cpu_done    (cpu_done),
        .cpu_reset   (cpu_reset),
        .busy        (busy),
        .finished    (finished),
        .timed_out   (timed_out),
        .cycle_count (cycle_count)
    );

    run_ctrl #(
        .CW          (6),
        .RST_CYCLES  (3),
        .TIMEOUT_CYC (6'd8)
    ) dut_s (
        .clk         (clk),
        .reset       (reset),
        .start       (start_s),
        .ack         (ack_s),
        .cpu_done    (done_s),
        .cpu_reset   (cpu_reset_s),
        .busy        (busy_s),
        .finished    (finished_s),
        .timed_out   (timed_out_s),
        .cycle_count (count_s)
    );

    typedef struct packed {
        logic        start;
        logic        ack;
        logic        done;
        logic        cr;
        logic        busy;
        logic        fin;
        logic        to;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    task automatic add(input logic s, input logic a, input logic d,
                       input logic cr, input logic b, input logic f, input logic t,
                       input int c);
        vec_t v;
        v.start = s; v.ack = a; v.done = d;
        v.cr = cr; v.busy = b; v.fin = f; v.to = t; v.cnt = 16'(c);
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t e;

        // Run 1: done 10 clocks after cpu_reset falls, then ack.
        add(1,0,0, 1,1,0,0, 0);
        add(0,0,0, 1,1,0,0, 0);
        add(0,0,0, 0,1,0,0, 0);
        for (int k = 1; k <= 10; k++) add(0,0,0, 0,1,0,0, k);
        add(0,0,1, 1,0,1,0, 10);
        add(0,0,0, 1,0,1,0, 10);
        add(0,1,0, 1,0,0,0, 10);
        add(0,0,0, 1,0,0,0, 10);
        // Run 2: done during RESET_CPU and start during RUN are ignored.
        add(1,0,0, 1,1,0,0, 0);
        add(0,0,1, 1,1,0,0, 0);
        add(0,0,1, 0,1,0,0, 0);
        add(1,0,0, 0,1,0,0, 1);
        add(1,0,0, 0,1,0,0, 2);
        add(0,0,1, 1,0,1,0, 2);
        add(1,0,0, 1,0,1,0, 2);
        add(1,1,0, 1,0,0,0, 2);
        add(0,0,0, 1,0,0,0, 2);
        // Run 3: start+ack together in IDLE, run to count 5.
        add(1,1,0, 1,1,0,0, 0);
        add(0,0,0, 1,1,0,0, 0);
        add(0,0,0, 0,1,0,0, 0);
        for (int k = 1; k <= 5; k++) add(0,0,0, 0,1,0,0, k);

        reset = 1'b0;
        start = 0; ack = 0; cpu_done = 0;
        start_s = 0; ack_s = 0; done_s = 0;
        step();
        step();
        chk("reset flags", {cpu_reset, busy, finished, timed_out}, 4'b1000);
        chk("reset count", cycle_count, 0);
        chk("reset small count", count_s, 0);
        reset = 1'b1;
        step();
        chk("idle after release", {cpu_reset, busy, finished, timed_out}, 4'b1000);

        foreach (vecs[i]) begin
            start    = vecs[i].start;
            ack      = vecs[i].ack;
            cpu_done = vecs[i].done;
            sb.push_back(vecs[i]);
            step();
            e = sb.pop_front();
            chk($sformatf("row%0d flags", i), {cpu_reset, busy, finished, timed_out},
                {e.cr, e.busy, e.fin, e.to});
            chk($sformatf("row%0d count", i), cycle_count, e.cnt);
        end
        start = 0; ack = 0; cpu_done = 0;

        // Asynchronous reset mid-run at count 5.
        #2 reset = 1'b0;
        #1;
        chk("async rst flags", {cpu_reset, busy, finished, timed_out}, 4'b1000);
        chk("async rst count", cycle_count, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        cpu_done = 1;
        step();
        cpu_done = 0;
        chk("post rst idle", {cpu_reset, busy, finished, timed_out}, 4'b1000);
        step();
        chk("post rst still idle", {cpu_reset, busy, finished, timed_out}, 4'b1000);

`ifdef RUN_CTRL_TIMEOUT_EN
        start = 1;
        step();
        start = 0;
        step();
        step();
        for (int k = 0; k < 20; k++) step();
        chk("to pre flags", {cpu_reset, busy, finished, timed_out}, 4'b0100);
        chk("to pre count", cycle_count, 20);
        step();
        chk("to flags", {cpu_reset, busy, finished, timed_out}, 4'b1001);
        chk("to count", cycle_count, 20);
        step();
        chk("to hold", {cpu_reset, busy, finished, timed_out}, 4'b1001);
        ack = 1;
        step();
        ack = 0;
        chk("to ack flags", {cpu_reset, busy, finished, timed_out}, 4'b1000);
        chk("to ack count", cycle_count, 20);
`endif

        // Small instance: RST_CYCLES=3 latency, done at limit count 8.
        start_s = 1;
        step();
        start_s = 0;
        chk("s busy 1clk", {cpu_reset_s, busy_s}, 2'b11);
        step();
        step();
        chk("s cpu_reset held", {cpu_reset_s, busy_s}, 2'b11);
        step();
        chk("s cpu_reset low", {cpu_reset_s, busy_s}, 2'b01);
        for (int k = 0; k < 8; k++) step();
        chk("s count 8", count_s, 8);
        done_s = 1;
        step();
        done_s = 0;
        chk("s prio flags", {cpu_reset_s, busy_s, finished_s, timed_out_s}, 4'b1010);
        chk("s prio count", count_s, 8);
        ack_s = 1;
        step();
        ack_s = 0;
        start_s = 1;
        step();
        start_s = 0;
        chk("s restart count", count_s, 0);
        step();
        step();
        step();
`ifdef RUN_CTRL_TIMEOUT_EN
        for (int k = 0; k < 8; k++) step();
        step();
        chk("s to flags", {cpu_reset_s, busy_s, finished_s, timed_out_s}, 4'b1001);
        chk("s to count", count_s, 8);
`else
        for (int k = 0; k < 70; k++) step();
        chk("s sat flags", {cpu_reset_s, busy_s, finished_s, timed_out_s}, 4'b0100);
        chk("s sat count", count_s, 63);
        step();
        chk("s sat hold", count_s, 63);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
